// File: rtl/ibex_register_file_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | ibex_register_file_mp: multi-read-port register file with two write ports, optional  |
// | write-through bypass and a per-register pending scoreboard.   Revision: 1.0          |
// +--------------------------------------------------------------------------------------+
module ibex_register_file_mp #(
  parameter bit          RV32E        = 1'b0,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NumReadPorts = 2,
  parameter bit          WriteThrough = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [5*NumReadPorts-1:0]      raddr_i,
  output logic [DataWidth*NumReadPorts-1:0] rdata_o,
  output logic [NumReadPorts-1:0]        rvalid_o,
  input  logic [4:0]                     waddr_a_i,
  input  logic [DataWidth-1:0]           wdata_a_i,
  input  logic                           we_a_i,
  input  logic [4:0]                     waddr_b_i,
  input  logic [DataWidth-1:0]           wdata_b_i,
  input  logic                           we_b_i,
  input  logic                           issue_i,
  input  logic [4:0]                     issue_addr_i,
  output logic [31:0]                    pending_o,
  output logic [5:0]                     pending_cnt_o
);

  // x0 and, in RV32E, x16..x31 are hardwired: never stored, never pending.
  function automatic logic addr_ok(input logic [4:0] addr);
    addr_ok = (addr != 5'd0) && !(RV32E && addr[4]);
  endfunction

  logic we_a_ok, we_b_ok, issue_ok;
  assign we_a_ok  = we_a_i  && addr_ok(waddr_a_i);
  assign we_b_ok  = we_b_i  && addr_ok(waddr_b_i);
  assign issue_ok = issue_i && addr_ok(issue_addr_i);

  logic [DataWidth-1:0] rf_q [32];
  logic [DataWidth-1:0] rf_d [32];
  logic [31:0]          pending_q, pending_d;
  logic [5:0]           cnt_q, cnt_d;

  always_comb begin
    rf_d      = rf_q;
    pending_d = pending_q;
    if (we_a_ok) begin
      rf_d[waddr_a_i]      = wdata_a_i;
      pending_d[waddr_a_i] = 1'b0;
    end
    // B is the younger result and issue is younger than either write.
    if (we_b_ok) begin
      rf_d[waddr_b_i]      = wdata_b_i;
      pending_d[waddr_b_i] = 1'b0;
    end
    if (issue_ok) begin
      pending_d[issue_addr_i] = 1'b1;
    end
    cnt_d = '0;
    for (int i = 0; i < 32; i++) begin
      cnt_d = cnt_d + 6'(pending_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_q      <= '{default: '0};
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      rf_q      <= rf_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending_o     = pending_q;
  assign pending_cnt_o = cnt_q;

  for (genvar p = 0; p < NumReadPorts; p++) begin : g_read
    logic [4:0]           raddr;
    logic [DataWidth-1:0] rdata;
    logic                 rvalid;

    assign raddr = raddr_i[5*p +: 5];

    always_comb begin
      rdata  = rf_q[raddr];
      rvalid = !pending_q[raddr];
      if (!addr_ok(raddr)) begin
        rdata  = '0;
        rvalid = 1'b1;
      end else if (WriteThrough && we_b_ok && (waddr_b_i == raddr)) begin
        rdata  = wdata_b_i;
        rvalid = 1'b1;
      end else if (WriteThrough && we_a_ok && (waddr_a_i == raddr)) begin
        rdata  = wdata_a_i;
        rvalid = 1'b1;
      end
    end

    assign rdata_o[DataWidth*p +: DataWidth] = rdata;
    assign rvalid_o[p]                       = rvalid;
  end : g_read

endmodule
`default_nettype wire

// File: tb/tb_ibex_register_file_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | tb_ibex_register_file_mp: bench for a full RV32I/write-through instance and an        |
// | RV32E/registered-read instance driven by the same stimulus.   Revision: 1.0           |
// +--------------------------------------------------------------------------------------+
module tb_ibex_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  raddr;
  logic [4:0]  waddr_a, waddr_b, issue_addr;
  logic [31:0] wdata_a, wdata_b;
  logic        we_a, we_b, issue;

  logic [63:0] rd0, rd1;
  logic [1:0]  rv0, rv1;
  logic [31:0] pend0, pend1;
  logic [5:0]  cnt0, cnt1;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ibex_register_file_mp #(.RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .WriteThrough(1'b1)) dut0 (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rd0), .rvalid_o(rv0),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
    .issue_i(issue), .issue_addr_i(issue_addr), .pending_o(pend0), .pending_cnt_o(cnt0)
  );

  ibex_register_file_mp #(.RV32E(1'b1), .DataWidth(32), .NumReadPorts(2), .WriteThrough(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rd1), .rvalid_o(rv1),
    .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
    .issue_i(issue), .issue_addr_i(issue_addr), .pending_o(pend1), .pending_cnt_o(cnt1)
  );

  // Reference state per configuration: c=0 is dut0 (32 regs, bypass), c=1 is dut1 (16 regs, no bypass).
  logic [31:0] m_reg  [2][32];
  bit          m_pend [2][32];

  function automatic bit vaddr(input int c, input logic [4:0] a);
    return (a != 5'd0) && !(c == 1 && a >= 5'd16);
  endfunction

  function automatic void exp_read(input int c, input logic [4:0] a,
                                   output logic [31:0] d, output logic v);
    if (!vaddr(c, a)) begin
      d = 32'd0; v = 1'b1;
    end else if (c == 0 && we_b && vaddr(c, waddr_b) && waddr_b == a) begin
      d = wdata_b; v = 1'b1;
    end else if (c == 0 && we_a && vaddr(c, waddr_a) && waddr_a == a) begin
      d = wdata_a; v = 1'b1;
    end else begin
      d = m_reg[c][a]; v = !m_pend[c][a];
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input int c);
    logic [31:0] d, pv;
    logic        v;
    int          n;
    n = 0;
    pv = '0;
    for (int r = 0; r < 32; r++) begin
      pv[r] = m_pend[c][r];
      n += int'(m_pend[c][r]);
    end
    for (int p = 0; p < 2; p++) begin
      exp_read(c, raddr[5*p +: 5], d, v);
      chk($sformatf("m%0d_rdata%0d", c, p), c == 0 ? rd0[32*p +: 32] : rd1[32*p +: 32], 64'(d));
      chk($sformatf("m%0d_rvalid%0d", c, p), c == 0 ? 64'(rv0[p]) : 64'(rv1[p]), 64'(v));
    end
    chk($sformatf("m%0d_pending", c), c == 0 ? 64'(pend0) : 64'(pend1), 64'(pv));
    chk($sformatf("m%0d_cnt", c), c == 0 ? 64'(cnt0) : 64'(cnt1), 64'(n));
  endtask

  task automatic model_update();
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          m_reg[c][r] = '0; m_pend[c][r] = 1'b0;
        end
      end else begin
        if (we_a && vaddr(c, waddr_a)) begin m_reg[c][waddr_a] = wdata_a; m_pend[c][waddr_a] = 1'b0; end
        if (we_b && vaddr(c, waddr_b)) begin m_reg[c][waddr_b] = wdata_b; m_pend[c][waddr_b] = 1'b0; end
        if (issue && vaddr(c, issue_addr)) m_pend[c][issue_addr] = 1'b1;
      end
    end
  endtask

  task automatic idle();
    rst = 1'b0; we_a = 1'b0; we_b = 1'b0; issue = 1'b0;
    waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0; issue_addr = '0;
  endtask

  task automatic sample();
    #4;
    check_model(0);
    check_model(1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic we_a; logic [4:0] wa_a; logic [31:0] wd_a;
    logic we_b; logic [4:0] wa_b; logic [31:0] wd_b;
    logic iss;  logic [4:0] ia;
    logic [4:0] r0, r1;
    logic [31:0] d0; logic v0; logic [31:0] d1; logic v1; logic [5:0] cnt;
  } vec_t;

  vec_t tbl [15];

  task automatic setv(input int i, input int wea, input int waa, input int wda,
                      input int web, input int wab, input int wdb, input int iss, input int ia,
                      input int r0, input int r1, input int d0, input int v0,
                      input int d1, input int v1, input int cnt);
    tbl[i].we_a = 1'(wea); tbl[i].wa_a = 5'(waa); tbl[i].wd_a = 32'(wda);
    tbl[i].we_b = 1'(web); tbl[i].wa_b = 5'(wab); tbl[i].wd_b = 32'(wdb);
    tbl[i].iss  = 1'(iss); tbl[i].ia   = 5'(ia);
    tbl[i].r0   = 5'(r0);  tbl[i].r1   = 5'(r1);
    tbl[i].d0   = 32'(d0); tbl[i].v0   = 1'(v0);
    tbl[i].d1   = 32'(d1); tbl[i].v1   = 1'(v1); tbl[i].cnt = 6'(cnt);
  endtask

  initial begin
    //       we_a wa  wd_a         we_b wa wd_b iss ia r0 r1  d0           v0 d1           v1 cnt
    setv( 0, 1,  5, 32'hDEADBEEF, 0,  0, 0,    0, 0,  5, 0, 32'hDEADBEEF, 1, 0,           1, 0);
    setv( 1, 0,  0, 0,            0,  0, 0,    0, 0,  5, 0, 32'hDEADBEEF, 1, 0,           1, 0);
    setv( 2, 1,  7, 32'h11,       1,  7, 'h22, 0, 0,  7, 5, 32'h22,       1, 32'hDEADBEEF,1, 0);
    setv( 3, 0,  0, 0,            0,  0, 0,    0, 0,  7, 7, 32'h22,       1, 32'h22,       1, 0);
    setv( 4, 0,  0, 0,            0,  0, 0,    1, 3,  3, 7, 0,            1, 32'h22,       1, 0);
    setv( 5, 0,  0, 0,            0,  0, 0,    0, 0,  3, 7, 0,            0, 32'h22,       1, 1);
    setv( 6, 0,  0, 0,            1,  3, 'h55, 0, 0,  3, 7, 32'h55,       1, 32'h22,       1, 1);
    setv( 7, 0,  0, 0,            0,  0, 0,    0, 0,  3, 7, 32'h55,       1, 32'h22,       1, 0);
    setv( 8, 1,  9, 32'hA5A5,     0,  0, 0,    1, 9,  9, 3, 32'hA5A5,     1, 32'h55,       1, 0);
    setv( 9, 0,  0, 0,            0,  0, 0,    0, 0,  9, 3, 32'hA5A5,     0, 32'h55,       1, 1);
    setv(10, 0,  0, 0,            0,  0, 0,    1, 9,  9, 3, 32'hA5A5,     0, 32'h55,       1, 1);
    setv(11, 1,  0, 1,            0,  0, 0,    0, 0,  0, 9, 0,            1, 32'hA5A5,     0, 1);
    setv(12, 0,  0, 0,            0,  0, 0,    1, 0,  0, 9, 0,            1, 32'hA5A5,     0, 1);
    setv(13, 1,  9, 32'h1234,     0,  0, 0,    0, 0,  9, 0, 32'h1234,     1, 0,            1, 1);
    setv(14, 0,  0, 0,            0,  0, 0,    0, 0,  9, 0, 32'h1234,     1, 0,            1, 0);

    idle();
    raddr = {5'd0, 5'd5};
    rst = 1'b1;
    #1;
    tick();
    tick();
    rst = 1'b0;

    sample();
    chk("reset_cnt", 64'(cnt0), 64'd0);
    chk("reset_pending", 64'(pend0), 64'd0);
    chk("reset_x5", rd0[31:0], 64'd0);
    tick();

    for (int i = 0; i < 15; i++) begin
      idle();
      we_a = tbl[i].we_a; waddr_a = tbl[i].wa_a; wdata_a = tbl[i].wd_a;
      we_b = tbl[i].we_b; waddr_b = tbl[i].wa_b; wdata_b = tbl[i].wd_b;
      issue = tbl[i].iss; issue_addr = tbl[i].ia;
      raddr = {tbl[i].r1, tbl[i].r0};
      sample();
      chk($sformatf("vec%0d_d0", i), 64'(rd0[31:0]), 64'(tbl[i].d0));
      chk($sformatf("vec%0d_v0", i), 64'(rv0[0]), 64'(tbl[i].v0));
      chk($sformatf("vec%0d_d1", i), 64'(rd0[63:32]), 64'(tbl[i].d1));
      chk($sformatf("vec%0d_v1", i), 64'(rv0[1]), 64'(tbl[i].v1));
      chk($sformatf("vec%0d_cnt", i), 64'(cnt0), 64'(tbl[i].cnt));
      tick();
    end

    // RV32E: upper registers and x0 are hardwired.
    idle();
    we_a = 1'b1; waddr_a = 5'd20; wdata_a = 32'hFF; issue = 1'b1; issue_addr = 5'd20;
    raddr = {5'd20, 5'd20};
    sample();
    chk("e_wt_x20_d", 64'(rd1[31:0]), 64'd0);
    tick();
    idle();
    we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'h1;
    sample();
    chk("e_x20_d", 64'(rd1[31:0]), 64'd0);
    chk("e_x20_v", 64'(rv1[0]), 64'd1);
    chk("e_pending", 64'(pend1), 64'd0);
    chk("i_x20_v", 64'(rv0[0]), 64'd0);
    chk("i_x20_pend", 64'(pend0[20]), 64'd1);
    tick();
    idle();
    raddr = {5'd0, 5'd0};
    sample();
    chk("e_x0_d", 64'(rd1[31:0]), 64'd0);
    chk("i_x0_d", 64'(rd0[31:0]), 64'd0);
    tick();

    // Fill the scoreboard, then reset with a write in flight.
    for (int r = 1; r < 32; r++) begin
      idle();
      issue = 1'b1; issue_addr = 5'(r);
      raddr = {5'(r), 5'(r - 1)};
      sample();
      tick();
    end
    idle();
    sample();
    chk("fill_cnt", 64'(cnt0), 64'd31);
    chk("fill_cnt_e", 64'(cnt1), 64'd15);
    rst = 1'b1; we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'h77; issue = 1'b1; issue_addr = 5'd6;
    tick();
    idle();
    raddr = {5'd6, 5'd5};
    sample();
    chk("rst_mid_cnt", 64'(cnt0), 64'd0);
    chk("rst_mid_pend", 64'(pend0), 64'd0);
    chk("rst_mid_x5", 64'(rd0[31:0]), 64'd0);
    chk("rst_mid_x5_v", 64'(rv0[0]), 64'd1);
    chk("rst_mid_cnt_e", 64'(cnt1), 64'd0);
    tick();

    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      we_a       = 1'($urandom_range(0, 1));
      we_b       = 1'($urandom_range(0, 1));
      issue      = 1'($urandom_range(0, 1));
      waddr_a    = 5'($urandom_range(0, 31));
      waddr_b    = ($urandom_range(0, 3) == 0) ? waddr_a : 5'($urandom_range(0, 31));
      issue_addr = ($urandom_range(0, 3) == 0) ? waddr_b : 5'($urandom_range(0, 31));
      wdata_a    = $urandom;
      wdata_b    = $urandom;
      raddr[4:0] = ($urandom_range(0, 2) == 0) ? waddr_b : 5'($urandom_range(0, 31));
      raddr[9:5] = ($urandom_range(0, 2) == 0) ? waddr_a : 5'($urandom_range(0, 31));
      sample();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
